gpio_stream_tx: RTL and testbench



---
 rtl/gpio_stream_pkg.sv | 21 ++
 rtl/stream_sync_fifo.sv | 67 ++++++
 rtl/gpio_stream_tx.sv | 118 +++++++++++
 tb/tb_gpio_stream_tx.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpio_stream_pkg.sv
// gpio_stream_pkg: shared constants and types for the spectrometer pad-side stream.
//   - mprj_io pin indices of the off-chip stream interface
//   - default frame length used for auto-last insertion
//   - stream_beat_t: one stream beat {last, data}
package gpio_stream_pkg;

    // mprj_io pin mapping of the off-chip stream
    localparam int unsigned OUT_DATA_LSB = 8;
    localparam int unsigned OUT_LAST     = 24;
    localparam int unsigned OUT_VALID    = 25;
    localparam int unsigned OUT_READY    = 26;

    localparam int unsigned STREAM_DATA_W     = 16;
    localparam int unsigned DEFAULT_FRAME_LEN = 1536;

    typedef struct packed {
        logic                     last;
        logic [STREAM_DATA_W-1:0] data;
    } stream_beat_t;

endpackage

// File: rtl/stream_sync_fifo.sv
// stream_sync_fifo: synchronous FIFO of DEPTH entries with registered full/empty.
//   clock, resetb : clock, asynchronous active-low reset
//   push, wdata   : write request and data (ignored while full)
//   pop, rdata    : read request (ignored while empty) and head-of-queue data
//   full, empty   : registered status flags
//   level         : current occupancy (0..DEPTH)
module stream_sync_fifo #(
    parameter int unsigned W     = 17,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     resetb,
    input  logic                     push,
    input  logic [W-1:0]             wdata,
    input  logic                     pop,
    output logic [W-1:0]             rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wptr;
    logic [AW:0]  rptr;
    logic [AW:0]  wptr_next;
    logic [AW:0]  rptr_next;
    logic         do_push;
    logic         do_pop;

    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    // Pointers carry one extra wrap bit so full and empty are distinguishable
    always_comb begin
        wptr_next = wptr + (AW+1)'(do_push);
        rptr_next = rptr + (AW+1)'(do_pop);
    end

    // Storage array, no reset needed
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wptr[AW-1:0]] <= wdata;
        end
    end

    // Pointers and flags computed from next pointers so the flags stay registered
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            wptr  <= '0;
            rptr  <= '0;
            full  <= 1'b0;
            empty <= 1'b1;
        end else begin
            wptr  <= wptr_next;
            rptr  <= rptr_next;
            full  <= (wptr_next[AW] != rptr_next[AW]) &&
                     (wptr_next[AW-1:0] == rptr_next[AW-1:0]);
            empty <= (wptr_next == rptr_next);
        end
    end

    assign rdata = mem[rptr[AW-1:0]];
    assign level = wptr - rptr;

endmodule

// File: rtl/gpio_stream_tx.sv
// gpio_stream_tx: pad-side transmitter of the 16-bit spectrometer output stream.
// Buffers an internal ready/valid stream in a small FIFO, drives a registered
// pad stage (valid/last/data), generates pad output enables and forces
// pad_last every FRAME_LEN beats so the collector always sees a frame end.
//   clock, resetb      : clock, asynchronous active-low reset
//   enable             : when low no new pad beat is launched
//   s_valid/s_ready/s_data/s_last : internal input stream
//   pad_ready          : out_ready from the pad (used combinationally)
//   pad_valid/pad_last/pad_data   : registered pad stream
//   pad_oeb            : pad output enables (0 drives), all 1s in reset
//   beat_cnt           : beats transferred in the current frame
//   fifo_level         : FIFO occupancy
// Optional: define GPIO_STREAM_TX_BITREV_EN to bit-reverse pad_data.
module gpio_stream_tx
    import gpio_stream_pkg::*;
#(
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned FRAME_LEN = DEFAULT_FRAME_LEN,
    parameter int unsigned CNT_W     = 11
) (
    input  logic                     clock,
    input  logic                     resetb,
    input  logic                     enable,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic [DATA_W-1:0]        s_data,
    input  logic                     s_last,
    input  logic                     pad_ready,
    output logic                     pad_valid,
    output logic                     pad_last,
    output logic [DATA_W-1:0]        pad_data,
    output logic [DATA_W+1:0]        pad_oeb,
    output logic [CNT_W-1:0]         beat_cnt,
    output logic [$clog2(DEPTH):0]   fifo_level
);

    localparam int unsigned BEAT_W = DATA_W + 1;

    logic              active;
    logic              full;
    logic              empty;
    logic              push;
    logic              pop;
    logic              xfer;
    logic [BEAT_W-1:0] rd_beat;
    logic [DATA_W-1:0] head_data;
    logic              head_last;
    logic [DATA_W-1:0] pad_map;
    logic [CNT_W-1:0]  cnt_next;

    // active marks the first edge after reset release; gates input and pad drive
    assign s_ready = active & ~full;
    assign push    = s_valid & s_ready;
    assign xfer    = pad_valid & pad_ready;
    assign pop     = (~pad_valid | xfer) & ~empty & enable;

    assign {head_last, head_data} = rd_beat;

    stream_sync_fifo #(
        .W     (BEAT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock  (clock),
        .resetb (resetb),
        .push   (push),
        .wdata  ({s_last, s_data}),
        .pop    (pop),
        .rdata  (rd_beat),
        .full   (full),
        .empty  (empty),
        .level  (fifo_level)
    );

    // Beat count after this edge's transfer; a transferred last closes the frame
    always_comb begin
        cnt_next = beat_cnt;
        if (xfer) begin
            cnt_next = pad_last ? '0 : beat_cnt + CNT_W'(1);
        end
    end

    // Pad data mapping
    always_comb begin
        pad_map = '0;
`ifdef GPIO_STREAM_TX_BITREV_EN
        for (int unsigned i = 0; i < DATA_W; i++) begin
            pad_map[i] = head_data[DATA_W-1-i];
        end
`else
        pad_map = head_data;
`endif
    end

    // Pad output stage and frame counter
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            active    <= 1'b0;
            pad_oeb   <= '1;
            pad_valid <= 1'b0;
            pad_last  <= 1'b0;
            pad_data  <= '0;
            beat_cnt  <= '0;
        end else begin
            active   <= 1'b1;
            pad_oeb  <= '0;
            beat_cnt <= cnt_next;
            if (pop) begin
                pad_valid <= 1'b1;
                pad_last  <= head_last | (cnt_next == CNT_W'(FRAME_LEN - 1));
                pad_data  <= pad_map;
            end else if (xfer) begin
                pad_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_gpio_stream_tx.sv
// tb_gpio_stream_tx: self-checking bench for gpio_stream_tx.
// Accepted input beats are queued; every pad transfer pops the queue and is
// checked against data, expected last (own frame model) and beat_cnt.
module tb_gpio_stream_tx;
    import gpio_stream_pkg::*;

    localparam int unsigned DATA_W    = 16;
    localparam int unsigned DEPTH     = 4;
    localparam int unsigned FRAME_LEN = 1536;
    localparam int unsigned CNT_W     = 11;

`ifdef GPIO_STREAM_TX_BITREV_EN
    localparam logic [15:0] EXP_A1 = 16'h8000;
`else
    localparam logic [15:0] EXP_A1 = 16'h0001;
`endif

    logic              clock;
    logic              resetb;
    logic              enable;
    logic              s_valid;
    logic              s_ready;
    logic [DATA_W-1:0] s_data;
    logic              s_last;
    logic              pad_ready;
    logic              pad_valid;
    logic              pad_last;
    logic [DATA_W-1:0] pad_data;
    logic [DATA_W+1:0] pad_oeb;
    logic [CNT_W-1:0]  beat_cnt;
    logic [2:0]        fifo_level;

    int vectors;
    int miscompares;

    stream_beat_t sb[$];
    int model_cnt;
    int obs_cnt;
    int last_len;
    int n_last;

    gpio_stream_tx #(
        .DATA_W    (DATA_W),
        .DEPTH     (DEPTH),
        .FRAME_LEN (FRAME_LEN),
        .CNT_W     (CNT_W)
    ) dut (
        .clock      (clock),
        .resetb     (resetb),
        .enable     (enable),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_data     (s_data),
        .s_last     (s_last),
        .pad_ready  (pad_ready),
        .pad_valid  (pad_valid),
        .pad_last   (pad_last),
        .pad_data   (pad_data),
        .pad_oeb    (pad_oeb),
        .beat_cnt   (beat_cnt),
        .fifo_level (fifo_level)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] exp_pad(input logic [15:0] d);
        logic [15:0] r;
        r = d;
`ifdef GPIO_STREAM_TX_BITREV_EN
        for (int i = 0; i < 16; i++) r[i] = d[15-i];
`endif
        return r;
    endfunction

    // One clock: scoreboard at the falling edge, return 1 time unit after the rising edge
    task automatic tick();
        stream_beat_t b;
        logic         exp_last;
        @(negedge clock);
        if (resetb) begin
            if (s_valid && s_ready) begin
                b.last = s_last;
                b.data = s_data;
                sb.push_back(b);
            end
            if (pad_valid && pad_ready) begin
                check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) begin
                    b = sb.pop_front();
                    exp_last = b.last || (model_cnt == int'(FRAME_LEN) - 1);
                    check("pad_data", 32'(pad_data), 32'(exp_pad(b.data)));
                    check("pad_last", 32'(pad_last), 32'(exp_last));
                    check("beat_cnt", 32'(beat_cnt), 32'(model_cnt));
                    model_cnt = exp_last ? 0 : model_cnt + 1;
                end
                obs_cnt++;
                if (pad_last) begin
                    last_len = obs_cnt;
                    n_last++;
                    obs_cnt = 0;
                end
            end
        end
        @(posedge clock);
        #1;
    endtask

    task automatic drive_beats(input int n, input int last_at, output int cycles);
        int   i;
        logic acc;
        i = 0;
        cycles = 0;
        s_data = 16'($urandom);
        while (i < n && cycles < n * 4 + 20) begin
            s_valid = 1'b1;
            s_last  = (i + 1 == last_at);
            acc     = s_ready;
            tick();
            cycles++;
            if (acc) begin
                i++;
                s_data = 16'($urandom);
            end
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        check("drive_accepted", 32'(i), 32'(n));
    endtask

    task automatic drain();
        int k;
        k = 0;
        while ((sb.size() != 0 || pad_valid) && k < 200) begin
            tick();
            k++;
        end
        check("drain_queue", 32'(sb.size()), 32'd0);
        check("drain_level", 32'(fifo_level), 32'd0);
    endtask

    initial begin
        int idx;
        int cyc;
        logic acc;
        vectors = 0; miscompares = 0;
        model_cnt = 0; obs_cnt = 0; last_len = 0; n_last = 0;
        resetb = 1'b0; enable = 1'b1; pad_ready = 1'b1;
        s_valid = 1'b0; s_data = '0; s_last = 1'b0;

        // Reset values
        #12;
        check("rst_pad_valid", 32'(pad_valid), 32'd0);
        check("rst_pad_last", 32'(pad_last), 32'd0);
        check("rst_pad_data", 32'(pad_data), 32'd0);
        check("rst_pad_oeb", 32'(pad_oeb), 32'h3FFFF);
        check("rst_beat_cnt", 32'(beat_cnt), 32'd0);
        check("rst_level", 32'(fifo_level), 32'd0);
        check("rst_s_ready", 32'(s_ready), 32'd0);
        @(posedge clock); #1;
        resetb = 1'b1;
        tick();
        check("oeb_released", 32'(pad_oeb), 32'd0);
        check("ready_released", 32'(s_ready), 32'd1);

        // Three beats, latency and back-to-back output
        s_valid = 1'b1; s_data = 16'h0001;
        tick();
        check("lat_valid_e1", 32'(pad_valid), 32'd0);
        s_data = 16'hA5C3;
        tick();
        check("lat_valid_e2", 32'(pad_valid), 32'd1);
        check("lat_data_a1", 32'(pad_data), 32'(EXP_A1));
        s_data = 16'h1234;
        tick();
        check("seq_data_a2", 32'(pad_data), 32'(exp_pad(16'hA5C3)));
        s_valid = 1'b0;
        tick();
        check("seq_data_a3", 32'(pad_data), 32'(exp_pad(16'h1234)));
        tick();
        check("seq_idle", 32'(pad_valid), 32'd0);

        // Backpressure: FIFO fills behind a stalled pad beat
        pad_ready = 1'b0;
        idx = 0;
        for (int c = 0; c < 10; c++) begin
            s_valid = 1'b1;
            s_data  = 16'(16'hB000 + idx);
            acc     = s_ready;
            tick();
            if (acc) idx++;
        end
        s_valid = 1'b0;
        check("bp_accepted", 32'(idx), 32'd5);
        check("bp_level", 32'(fifo_level), 32'd4);
        check("bp_s_ready", 32'(s_ready), 32'd0);
        check("bp_valid", 32'(pad_valid), 32'd1);
        check("bp_hold_data", 32'(pad_data), 32'(exp_pad(16'hB000)));
        pad_ready = 1'b1;
        drain();

        // Close the open frame with an explicit last
        drive_beats(1, 1, cyc);
        drain();
        check("close_cnt", 32'(beat_cnt), 32'd0);

        // Full frame without s_last: auto-last on beat 1536 at one beat per cycle
        n_last = 0;
        drive_beats(1536, 0, cyc);
        check("full_throughput", 32'(cyc), 32'd1536);
        drain();
        check("full_last_len", 32'(last_len), 32'd1536);
        check("full_n_last", 32'(n_last), 32'd1);
        check("full_cnt_zero", 32'(beat_cnt), 32'd0);

        // Short frame then auto-last counted from the short frame's end
        drive_beats(100, 100, cyc);
        drain();
        check("short_last_len", 32'(last_len), 32'd100);
        check("short_cnt_zero", 32'(beat_cnt), 32'd0);
        n_last = 0;
        drive_beats(1536, 0, cyc);
        drain();
        check("after_last_len", 32'(last_len), 32'd1536);
        check("after_n_last", 32'(n_last), 32'd1);

        // enable dropped while a beat is on the pad
        s_valid = 1'b1; s_data = 16'hC0DE;
        tick();
        s_valid = 1'b0;
        tick();
        check("en_valid_before", 32'(pad_valid), 32'd1);
        enable = 1'b0;
        tick();
        check("en_valid_drop", 32'(pad_valid), 32'd0);
        drive_beats(4, 0, cyc);
        tick();
        check("en_level_full", 32'(fifo_level), 32'd4);
        check("en_s_ready", 32'(s_ready), 32'd0);
        check("en_valid_held", 32'(pad_valid), 32'd0);
        enable = 1'b1;
        tick();
        check("en_resume_valid", 32'(pad_valid), 32'd1);
        drain();

        // Asynchronous reset in the middle of a frame
        drive_beats(700, 0, cyc);
        #2;
        resetb = 1'b0;
        #1;
        check("mid_rst_valid", 32'(pad_valid), 32'd0);
        check("mid_rst_oeb", 32'(pad_oeb), 32'h3FFFF);
        check("mid_rst_level", 32'(fifo_level), 32'd0);
        check("mid_rst_cnt", 32'(beat_cnt), 32'd0);
        check("mid_rst_ready", 32'(s_ready), 32'd0);
        sb.delete();
        model_cnt = 0; obs_cnt = 0; n_last = 0;
        tick();
        resetb = 1'b1;
        tick();
        check("mid_oeb_release", 32'(pad_oeb), 32'd0);
        drive_beats(1536, 0, cyc);
        drain();
        check("post_rst_last_len", 32'(last_len), 32'd1536);
        check("post_rst_n_last", 32'(n_last), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
